disc_arbiter: RTL

Round-robin arbiter that shares one DiscriminantCalculator instance among NUM_REQ ray requesters against a common sphere.
- Accepts ray requests and issues them one at a time on the calculator's InputValid/InputReady handshake.
- Captures the single-cycle OutputReady result and returns it to the owning requester through a depth-1 response slot per requester.
- Sits between per-pixel ray generators and the sphere intersection datapath; includes a watchdog for a stalled calculator.

---
 rtl/disc_arb_pkg.sv | 29 ++
 rtl/disc_arbiter_if.sv | 47 ++++
 rtl/rr_pick.sv | 27 ++
 rtl/disc_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/disc_arb_pkg.sv
// Shared types for the discriminant-calculator arbiter: FSM states, response slot and
// the operand bundle handed to the calculator.
package disc_arb_pkg;

  localparam int unsigned DefaultDataW = 16;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRes} state_e;

  typedef struct packed {
    logic signed [DefaultDataW-1:0] disc;
    logic signed [DefaultDataW-1:0] b;
    logic                           hit;
    logic                           err;
  } slot_t;

  typedef struct packed {
    logic signed [DefaultDataW-1:0] start_x;
    logic signed [DefaultDataW-1:0] start_y;
    logic signed [DefaultDataW-1:0] start_z;
    logic signed [DefaultDataW-1:0] dir_x;
    logic signed [DefaultDataW-1:0] dir_y;
    logic signed [DefaultDataW-1:0] dir_z;
    logic signed [DefaultDataW-1:0] sph_x;
    logic signed [DefaultDataW-1:0] sph_y;
    logic signed [DefaultDataW-1:0] sph_z;
    logic        [DefaultDataW-1:0] radius;
  } ray_op_t;

endpackage

// File: rtl/disc_arbiter_if.sv
// Requester, response and calculator-side signals of the arbiter. The arbiter uses the
// slave view; the surrounding environment (ray generators + calculator) uses master.
interface disc_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic signed [DATA_W-1:0]         sphere_x, sphere_y, sphere_z;
  logic        [DATA_W-1:0]         sphere_radius;
  logic        [NUM_REQ-1:0]        req_valid, req_ready;
  logic        [NUM_REQ*DATA_W-1:0] req_start_x, req_start_y, req_start_z;
  logic        [NUM_REQ*DATA_W-1:0] req_dir_x, req_dir_y, req_dir_z;
  logic        [NUM_REQ-1:0]        resp_valid, resp_ready;
  logic signed [DATA_W-1:0]         resp_disc, resp_b;
  logic        [IdW-1:0]            resp_id;
  logic                             resp_hit, resp_err;
  logic signed [DATA_W-1:0]         dc_start_x, dc_start_y, dc_start_z;
  logic signed [DATA_W-1:0]         dc_dir_x, dc_dir_y, dc_dir_z;
  logic signed [DATA_W-1:0]         dc_sphere_x, dc_sphere_y, dc_sphere_z;
  logic        [DATA_W-1:0]         dc_radius;
  logic                             dc_input_valid, dc_input_ready;
  logic                             dc_output_ready, dc_quick_intersects;
  logic signed [DATA_W-1:0]         dc_discriminant, dc_b;
  logic                             err_sticky;

  modport slave (
    input  sphere_x, sphere_y, sphere_z, sphere_radius, req_valid,
    input  req_start_x, req_start_y, req_start_z, req_dir_x, req_dir_y, req_dir_z,
    input  resp_ready, dc_input_ready, dc_output_ready, dc_quick_intersects,
    input  dc_discriminant, dc_b,
    output req_ready, resp_valid, resp_disc, resp_b, resp_id, resp_hit, resp_err,
    output dc_start_x, dc_start_y, dc_start_z, dc_dir_x, dc_dir_y, dc_dir_z,
    output dc_sphere_x, dc_sphere_y, dc_sphere_z, dc_radius, dc_input_valid, err_sticky
  );

  modport master (
    output sphere_x, sphere_y, sphere_z, sphere_radius, req_valid,
    output req_start_x, req_start_y, req_start_z, req_dir_x, req_dir_y, req_dir_z,
    output resp_ready, dc_input_ready, dc_output_ready, dc_quick_intersects,
    output dc_discriminant, dc_b,
    input  req_ready, resp_valid, resp_disc, resp_b, resp_id, resp_hit, resp_err,
    input  dc_start_x, dc_start_y, dc_start_z, dc_dir_x, dc_dir_y, dc_dir_z,
    input  dc_sphere_x, dc_sphere_y, dc_sphere_z, dc_radius, dc_input_valid, err_sticky
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [IdxW-1:0]    grant_o,
  output logic               found_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IdxW'((32'(ptr_i) + off) % NUM_REQ);
      if (!found_o && eligible_i[idx]) begin
        grant_o = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disc_arbiter.sv
// Round-robin arbiter sharing one discriminant calculator among NUM_REQ ray requesters,
// with a depth-1 response slot per requester and a watchdog on the calculator result.
module disc_arbiter
  import disc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned TIMEOUT = 15
) (
  input logic           CLK,
  input logic           aresetn,
  disc_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  state_e              state_q;
  logic [IdxW-1:0]     rr_ptr_q, grant_q;
  ray_op_t             op_q;
  logic                dc_valid_q;
  logic [WdW-1:0]      wd_q;
  slot_t               slot_q [NUM_REQ];
  logic [NUM_REQ-1:0]  full_q;
  logic                err_q;

  ray_op_t             lane_op [NUM_REQ];
  logic [NUM_REQ-1:0]  eligible;
  logic [IdxW-1:0]     pick;
  logic                found;

  // Operand structs are sized by DefaultDataW, so DATA_W must keep its default.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_op[i] = '{
      start_x: bus.req_start_x[i*DATA_W +: DATA_W],
      start_y: bus.req_start_y[i*DATA_W +: DATA_W],
      start_z: bus.req_start_z[i*DATA_W +: DATA_W],
      dir_x:   bus.req_dir_x[i*DATA_W +: DATA_W],
      dir_y:   bus.req_dir_y[i*DATA_W +: DATA_W],
      dir_z:   bus.req_dir_z[i*DATA_W +: DATA_W],
      sph_x:   bus.sphere_x,
      sph_y:   bus.sphere_y,
      sph_z:   bus.sphere_z,
      radius:  bus.sphere_radius
    };
  end

  assign eligible = bus.req_valid & ~full_q;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .eligible_i(eligible),
    .ptr_i     (rr_ptr_q),
    .grant_o   (pick),
    .found_o   (found)
  );

  always_ff @(posedge CLK) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      op_q       <= '0;
      dc_valid_q <= 1'b0;
      wd_q       <= '0;
      full_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
    end else begin
      // Pops never hit the lane being written: a full lane is never granted.
      full_q <= full_q & ~bus.resp_ready;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            op_q       <= lane_op[pick];
            grant_q    <= pick;
            rr_ptr_q   <= (pick == IdxW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            dc_valid_q <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (bus.dc_input_ready) begin
            dc_valid_q <= 1'b0;
            wd_q       <= '0;
            state_q    <= StWaitRes;
          end
        end
        StWaitRes: begin
          wd_q <= wd_q + 1'b1;
          if (bus.dc_output_ready) begin
            slot_q[grant_q] <= '{disc: bus.dc_discriminant, b: bus.dc_b,
                                 hit: bus.dc_quick_intersects, err: 1'b0};
            full_q[grant_q] <= 1'b1;
            state_q         <= StIdle;
          end else if (wd_q == WdW'(TIMEOUT - 1)) begin
            slot_q[grant_q] <= '{disc: '0, b: '0, hit: 1'b0, err: 1'b1};
            full_q[grant_q] <= 1'b1;
            err_q           <= 1'b1;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle && found && aresetn) ?
                         (NUM_REQ'(1) << pick) : '0;

  assign bus.dc_start_x     = op_q.start_x;
  assign bus.dc_start_y     = op_q.start_y;
  assign bus.dc_start_z     = op_q.start_z;
  assign bus.dc_dir_x       = op_q.dir_x;
  assign bus.dc_dir_y       = op_q.dir_y;
  assign bus.dc_dir_z       = op_q.dir_z;
  assign bus.dc_sphere_x    = op_q.sph_x;
  assign bus.dc_sphere_y    = op_q.sph_y;
  assign bus.dc_sphere_z    = op_q.sph_z;
  assign bus.dc_radius      = op_q.radius;
  assign bus.dc_input_valid = dc_valid_q;
  assign bus.resp_valid     = full_q;
  assign bus.err_sticky     = err_q;

  // Shared response bus shows the lowest-index full slot.
  always_comb begin
    bus.resp_id   = '0;
    bus.resp_disc = '0;
    bus.resp_b    = '0;
    bus.resp_hit  = 1'b0;
    bus.resp_err  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (full_q[i]) begin
        bus.resp_id   = IdxW'(i);
        bus.resp_disc = slot_q[i].disc;
        bus.resp_b    = slot_q[i].b;
        bus.resp_hit  = slot_q[i].hit;
        bus.resp_err  = slot_q[i].err;
      end
    end
  end

endmodule
